hdmi_link_sequencer: RTL and testbench

Per-port link bring-up sequencer for the QSFP-to-HDMI output path. It debounces the module-present/hot-plug signal and drives the QSFP module reset. It waits for the transceiver TX path to come out of reset, launches the sink I2C configuration, and asserts `run` once the link is up. One instance per QSFP port, in the system clock domain, between the board top and each HDMI output datapath.

---
 rtl/hdmi_link_sequencer.sv | 140 ++++++++++++++
 tb/tb_hdmi_link_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_link_sequencer.sv
// Per-port QSFP-to-HDMI link bring-up: hot-plug debounce, module reset, TX wait, sink config, run.
// Optional retry/backoff on configuration failure is enabled by defining HDMI_LINK_SEQ_RETRY_EN.
module hdmi_link_sequencer #(
    parameter int unsigned CLOCK_FREQUENCY   = 200_000_000,
    parameter int unsigned DEBOUNCE_US       = 10_000,
    parameter int unsigned RESET_HOLD_US     = 1_000,
    parameter int unsigned CONFIG_TIMEOUT_US = 100_000,
    parameter int unsigned RETRY_DELAY_US    = 500_000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       hpd_raw,
    input  logic       tx_ready,
    input  logic       config_done,
    input  logic       config_error,
    output logic       config_start,
    output logic       module_reset_n,
    output logic       run,
    output logic       hpd,
    output logic [2:0] state,
    output logic [7:0] retry_count
);

    localparam int unsigned US_CYCLES    = CLOCK_FREQUENCY / 1_000_000;
    localparam int unsigned DEB_CYCLES   = DEBOUNCE_US * US_CYCLES;
    localparam int unsigned HOLD_CYCLES  = RESET_HOLD_US * US_CYCLES;
    localparam int unsigned CFG_CYCLES   = CONFIG_TIMEOUT_US * US_CYCLES;
    localparam int unsigned RETRY_CYCLES = RETRY_DELAY_US * US_CYCLES;
    localparam int unsigned MAX_AB       = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CD       = (CFG_CYCLES > RETRY_CYCLES) ? CFG_CYCLES : RETRY_CYCLES;
    localparam int unsigned MAX_CYCLES   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W        = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DEB_W        = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_WAIT_TX = 3'd2,
        S_CONFIG  = 3'd3,
        S_RUN     = 3'd4,
        S_BACKOFF = 3'd5,
        S_FAULT   = 3'd6
    } state_t;

    state_t             cur_state;
    state_t             nxt_state;
    logic [CNT_W-1:0]   cnt;
    logic               hpd_meta;
    logic               hpd_sync;
    logic [DEB_W-1:0]   deb_cnt;
    logic               cfg_fail;

    // Two-flop synchronizer and debounce; counter only runs while the input disagrees with hpd
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hpd_meta <= 1'b0;
            hpd_sync <= 1'b0;
            hpd      <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            hpd_meta <= hpd_raw;
            hpd_sync <= hpd_meta;
            if (hpd_sync == hpd) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                hpd     <= hpd_sync;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Next-state logic; losing hpd overrides everything else
    always_comb begin
        nxt_state = cur_state;
        cfg_fail  = 1'b0;
        case (cur_state)
            S_IDLE:    if (hpd) nxt_state = S_RESET;
            S_RESET:   if (cnt == CNT_W'(HOLD_CYCLES - 1)) nxt_state = S_WAIT_TX;
            S_WAIT_TX: if (tx_ready) nxt_state = S_CONFIG;
            S_CONFIG: begin
                if (config_error) begin
                    cfg_fail = 1'b1;
                end else if (config_done) begin
                    nxt_state = S_RUN;
                end else if (cnt == CNT_W'(CFG_CYCLES - 1)) begin
                    cfg_fail = 1'b1;
                end
`ifdef HDMI_LINK_SEQ_RETRY_EN
                if (cfg_fail) nxt_state = S_BACKOFF;
`else
                if (cfg_fail) nxt_state = S_FAULT;
`endif
            end
            S_RUN:     if (!tx_ready) nxt_state = S_WAIT_TX;
`ifdef HDMI_LINK_SEQ_RETRY_EN
            S_BACKOFF: if (cnt == CNT_W'(RETRY_CYCLES - 1)) nxt_state = S_RESET;
`endif
            S_FAULT:   nxt_state = S_FAULT;
            default:   nxt_state = S_IDLE;
        endcase
        if (cur_state != S_IDLE && !hpd) nxt_state = S_IDLE;
    end

    // State register; outputs are registered from the next state so they align with it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_state      <= S_IDLE;
            cnt            <= '0;
            module_reset_n <= 1'b0;
            run            <= 1'b0;
            config_start   <= 1'b0;
        end else begin
            cur_state      <= nxt_state;
            cnt            <= (nxt_state != cur_state) ? '0 : cnt + CNT_W'(1);
            module_reset_n <= !(nxt_state == S_IDLE || nxt_state == S_RESET);
            run            <= (nxt_state == S_RUN);
            config_start   <= (nxt_state == S_CONFIG) && (cur_state != S_CONFIG);
        end
    end

    assign state = cur_state;

`ifdef HDMI_LINK_SEQ_RETRY_EN
    // Failed attempts since the last hot-plug, saturating
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_count <= 8'd0;
        end else if (nxt_state == S_IDLE && cur_state != S_IDLE) begin
            retry_count <= 8'd0;
        end else if (cur_state == S_CONFIG && nxt_state == S_BACKOFF && retry_count != 8'hFF) begin
            retry_count <= retry_count + 8'd1;
        end
    end
`else
    assign retry_count = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_link_sequencer.sv
// Randomized bench for hdmi_link_sequencer: a timeline model predicts every output change,
// and a negedge monitor pops and checks each change against it.
module tb_hdmi_link_sequencer;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int CFGTO = 50;
    localparam int RETRY = 20;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       hpd_raw;
    logic       tx_ready;
    logic       config_done;
    logic       config_error;
    logic       config_start;
    logic       module_reset_n;
    logic       run;
    logic       hpd;
    logic [2:0] state;
    logic [7:0] retry_count;

    hdmi_link_sequencer #(
        .CLOCK_FREQUENCY  (1_000_000),
        .DEBOUNCE_US      (DEB),
        .RESET_HOLD_US    (HOLD),
        .CONFIG_TIMEOUT_US(CFGTO),
        .RETRY_DELAY_US   (RETRY)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .hpd_raw       (hpd_raw),
        .tx_ready      (tx_ready),
        .config_done   (config_done),
        .config_error  (config_error),
        .config_start  (config_start),
        .module_reset_n(module_reset_n),
        .run           (run),
        .hpd           (hpd),
        .state         (state),
        .retry_count   (retry_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0] st;
        logic       hp;
        logic       mr;
        logic       rn;
        logic       cs;
        logic [7:0] rc;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t val;
    } exp_t;

    exp_t q[$];
    obs_t m;
    obs_t last_obs;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    function automatic obs_t sample();
        return obs_t'({state, hpd, module_reset_n, run, config_start, retry_count});
    endfunction

    // Expected output vector m from cycle c on; changes landing on the same cycle merge
    task automatic ev(input int c);
        exp_t e;
        if (q.size() > 0 && q[$].cyc == c) begin
            q[$].val = m;
        end else begin
            e.cyc = c;
            e.val = m;
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    // Monitor: every observed output change must be the next predicted one, on the predicted cycle
    always @(negedge clock) begin
        obs_t o;
        exp_t e;
        if (mon_en) begin
            o = sample();
            if (o !== last_obs) begin
                last_obs = o;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, o);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != cyc || e.val !== o) begin
                        bad++;
                        $display("FAIL event got cyc=%0d st=%0d hpd=%b mrst_n=%b run=%b cstart=%b retry=%0d required cyc=%0d st=%0d hpd=%b mrst_n=%b run=%b cstart=%b retry=%0d",
                                 cyc, o.st, o.hp, o.mr, o.rn, o.cs, o.rc,
                                 e.cyc, e.val.st, e.val.hp, e.val.mr, e.val.rn, e.val.cs, e.val.rc);
                    end
                end
            end
        end
    end

    task automatic run_iteration();
        int p, ws, c, k, f, o, u, t, n, drops;
`ifdef HDMI_LINK_SEQ_RETRY_EN
        int fails;
        fails = 0;
`endif
        tx_ready = 1'b0;
        drops = 0;
        f = 0;
        repeat ($urandom_range(2, 5)) step();

        // Short hot-plug glitches must never reach hpd
        n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) begin
            hpd_raw = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            hpd_raw = 1'b0;
            repeat ($urandom_range(4, 7)) step();
        end
        total++;
        if (hpd !== 1'b0 || state !== 3'd0 || module_reset_n !== 1'b0) begin
            bad++;
            $display("FAIL glitch got hpd=%b state=%0d mrst_n=%b required 0 0 0", hpd, state, module_reset_n);
        end

        // Plug in: 2 sync + DEB to hpd, then IDLE->RESET, RESET held HOLD cycles
        p = cyc;
        hpd_raw = 1'b1;
        m.hp = 1'b1; ev(p + 2 + DEB);
        m.st = 3'd1; ev(p + 3 + DEB);
        m.st = 3'd2; m.mr = 1'b1; ev(p + 3 + DEB + HOLD);
        ws = p + 3 + DEB + HOLD;

        while (1) begin
            if (!tx_ready) begin
                t = ws + $urandom_range(0, 4);
                wait_until(t);
                tx_ready = 1'b1;
                c = t + 1;
            end else begin
                c = ws + 1;
            end
            m.st = 3'd3; m.cs = 1'b1; ev(c);
            m.cs = 1'b0; ev(c + 1);
            o = $urandom_range(0, 3);
`ifdef HDMI_LINK_SEQ_RETRY_EN
            if (fails >= 2) o = 0;
`endif
            if (o == 3) begin
                f = c + CFGTO;
            end else begin
                k = $urandom_range(1, 8);
                f = c + k;
                wait_until(f - 1);
                config_done  = (o == 0 || o == 2);
                config_error = (o == 1 || o == 2);
                step();
                config_done  = 1'b0;
                config_error = 1'b0;
            end
            if (o == 0) begin
                m.st = 3'd4; m.rn = 1'b1; ev(f);
                if (drops < 1 && $urandom_range(0, 1) == 1) begin
                    drops++;
                    wait_until(f + $urandom_range(1, 5));
                    u = cyc;
                    tx_ready = 1'b0;
                    m.st = 3'd2; m.rn = 1'b0; ev(u + 1);
                    ws = u + 1;
                    continue;
                end
                break;
            end
`ifdef HDMI_LINK_SEQ_RETRY_EN
            fails++;
            m.st = 3'd5;
            if (m.rc != 8'hFF) m.rc = m.rc + 8'd1;
            ev(f);
            m.st = 3'd1; m.mr = 1'b0; ev(f + RETRY);
            m.st = 3'd2; m.mr = 1'b1; ev(f + RETRY + HOLD);
            ws = f + RETRY + HOLD;
`else
            m.st = 3'd6; ev(f);
            break;
`endif
        end

        wait_until(f + $urandom_range(1, 6));
        if ($urandom_range(0, 3) != 0) begin
            // Unplug: hpd drops after 2 + DEB, everything returns to idle one cycle later
            u = cyc;
            hpd_raw = 1'b0;
            m.hp = 1'b0; ev(u + 2 + DEB);
            m = '0; ev(u + 3 + DEB);
            wait_until(u + 5 + DEB);
        end else begin
            // Asynchronous reset: outputs clear with no clock edge
            u = cyc;
            m = '0; ev(u);
            reset_n = 1'b0;
            hpd_raw = 1'b0;
            tx_ready = 1'b0;
            #1;
            total++;
            if (run !== 1'b0 || module_reset_n !== 1'b0 || state !== 3'd0 || hpd !== 1'b0) begin
                bad++;
                $display("FAIL async_reset got run=%b mrst_n=%b state=%0d hpd=%b required 0 0 0 0",
                         run, module_reset_n, state, hpd);
            end
            step();
            step();
            reset_n = 1'b1;
            step();
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        hpd_raw      = 1'b0;
        tx_ready     = 1'b0;
        config_done  = 1'b0;
        config_error = 1'b0;
        m            = '0;
        last_obs     = '0;
        #1;
        total++;
        if (sample() !== obs_t'(0)) begin
            bad++;
            $display("FAIL reset_state got=%h required=0", sample());
        end
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        for (int it = 0; it < 30; it++) run_iteration();
        repeat (10) step();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL pending_events got=%0d required=0 (next at cyc %0d)", q.size(), q[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
